// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous instruction
// SRAM and produces the IF->ID bus. A one-entry skid buffer holds the fetched
// instruction while the hazard checker stalls the pipe, and a taken branch
// from ID squashes the wrong-path instruction currently in IF.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h1bfffffc,
    parameter int          FS_TO_DS_WD = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_stall,
    input  logic                   br_taken,
    input  logic [31:0]            br_target,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_we,
    output logic [31:0]            inst_sram_addr,
    input  logic [31:0]            inst_sram_rdata,
    output logic                   fs_to_ds_valid,
    output logic [FS_TO_DS_WD-1:0] fs_to_ds_bus
);

    logic        fs_valid;
    logic [31:0] fs_pc;
    logic        buf_valid;
    logic [31:0] inst_buf;
    logic        br_eff;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    // Redirect and next-PC selection; a branch seen during a stall is deferred
    always_comb begin
        br_eff = br_taken & ~is_stall;
        nextpc = br_eff ? br_target : fs_pc + 32'd4;
    end

    // SRAM request: re-present fs_pc while stalled, fixed start address in reset
    always_comb begin
        inst_sram_en   = ~reset & ~is_stall;
        inst_sram_we   = '0;
        inst_sram_addr = nextpc;
        if (reset) begin
            inst_sram_addr = RESET_PC + 32'd4;
        end else if (is_stall) begin
            inst_sram_addr = fs_pc;
        end
    end

    // IF->ID bus; the squashed sequential instruction is dropped on a redirect
    always_comb begin
        fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
        fs_to_ds_valid = fs_valid & ~br_eff;
        fs_to_ds_bus   = {fs_pc, fs_inst};
    end

    // PC and stage-valid register; both freeze while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_pc    <= RESET_PC;
            fs_valid <= 1'b0;
        end else if (!is_stall) begin
            fs_pc    <= nextpc;
            fs_valid <= 1'b1;
        end
    end

    // Skid buffer: capture rdata on the first stall cycle only, drop on release
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid <= 1'b0;
            inst_buf  <= '0;
        end else if (!is_stall) begin
            buf_valid <= 1'b0;
        end else if (fs_valid && !buf_valid) begin
            inst_buf  <= inst_sram_rdata;
            buf_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a per-cycle vector table walks reset release,
// stall with skid buffer, branch, branch-under-stall, PC wrap and a
// same-address redirect; hand-written sequences cover asynchronous reset.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        is_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_rdata;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;

    logic [31:0] mem_rdata = '0;
    logic        ovr_en;
    logic [31:0] ovr_val;

    int n_cmp = 0;
    int n_err = 0;

    if_stage #(
        .RESET_PC    (32'h1bfffffc),
        .FS_TO_DS_WD (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .is_stall        (is_stall),
        .br_taken        (br_taken),
        .br_target       (br_target),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM model: instruction word is {addr[15:0], 16'hc0de}
    always @(posedge clk) begin
        if (inst_sram_en) mem_rdata <= {inst_sram_addr[15:0], 16'hc0de};
    end

    assign inst_sram_rdata = ovr_en ? ovr_val : mem_rdata;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        ovr;
        logic        e_en;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic        e_buf;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //           rst   stall br    tgt           ovr   en    addr          vld   pc            inst          buf
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000000, 1'b0, 32'h1bfffffc, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000000, 1'b0, 32'h1bfffffc, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000000, 1'b0, 32'h1bfffffc, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000004, 1'b1, 32'h1c000000, 32'h0000c0de, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000008, 1'b1, 32'h1c000004, 32'h0004c0de, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h1c000008, 1'b1, 32'h1c000008, 32'h0008c0de, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c000008, 1'b1, 32'h1c000008, 32'h0008c0de, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h1c000008, 1'b1, 32'h1c000008, 32'h0008c0de, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'h1c00000c, 1'b1, 32'h1c000008, 32'h0008c0de, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000010, 1'b1, 32'h1c00000c, 32'h000cc0de, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 32'h1c000100, 1'b0, 1'b1, 32'h1c000100, 1'b0, 32'h1c000010, 32'h0010c0de, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000104, 1'b1, 32'h1c000100, 32'h0100c0de, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h1c000200, 1'b0, 1'b0, 32'h1c000104, 1'b1, 32'h1c000104, 32'h0104c0de, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 32'h1c000200, 1'b0, 1'b1, 32'h1c000200, 1'b0, 32'h1c000104, 32'h0104c0de, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1c000204, 1'b1, 32'h1c000200, 32'h0200c0de, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'hfffffffc, 1'b0, 1'b1, 32'hfffffffc, 1'b0, 32'h1c000204, 32'h0204c0de, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00000000, 1'b1, 32'hfffffffc, 32'hfffcc0de, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00000004, 1'b1, 32'h00000000, 32'h0000c0de, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 32'h00000008, 1'b0, 1'b1, 32'h00000008, 1'b0, 32'h00000004, 32'h0004c0de, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0000000c, 1'b1, 32'h00000008, 32'h0008c0de, 1'b0};

        reset     = 1'b1;
        is_stall  = 1'b0;
        br_taken  = 1'b0;
        br_target = '0;
        ovr_en    = 1'b0;
        ovr_val   = 32'hdeadbeef;
        @(posedge clk);
        #1;

        for (int i = 0; i < 20; i++) begin
            reset     = vecs[i].rst;
            is_stall  = vecs[i].stall;
            br_taken  = vecs[i].br;
            br_target = vecs[i].tgt;
            ovr_en    = vecs[i].ovr;
            @(negedge clk);
            chk($sformatf("v%0d.en", i),    64'(inst_sram_en),   64'(vecs[i].e_en));
            chk($sformatf("v%0d.we", i),    64'(inst_sram_we),   64'h0);
            chk($sformatf("v%0d.addr", i),  64'(inst_sram_addr), 64'(vecs[i].e_addr));
            chk($sformatf("v%0d.valid", i), 64'(fs_to_ds_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d.bus", i),   fs_to_ds_bus,        {vecs[i].e_pc, vecs[i].e_inst});
            chk($sformatf("v%0d.buf", i),   64'(dut.buf_valid),  64'(vecs[i].e_buf));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset while stalled with the skid buffer full
        br_taken = 1'b0;
        ovr_en   = 1'b0;
        is_stall = 1'b1;
        @(negedge clk);
        chk("astall.buf0", 64'(dut.buf_valid), 64'h0);
        @(posedge clk);
        #1;
        chk("astall.buf1", 64'(dut.buf_valid), 64'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst.valid", 64'(fs_to_ds_valid), 64'h0);
        chk("arst.buf",   64'(dut.buf_valid),  64'h0);
        chk("arst.en",    64'(inst_sram_en),   64'h0);
        chk("arst.addr",  64'(inst_sram_addr), 64'h1c000000);
        chk("arst.pc",    64'(fs_to_ds_bus[63:32]), 64'h1bfffffc);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        is_stall = 1'b0;
        @(negedge clk);
        chk("rel0.en",    64'(inst_sram_en),   64'h1);
        chk("rel0.addr",  64'(inst_sram_addr), 64'h1c000000);
        chk("rel0.valid", 64'(fs_to_ds_valid), 64'h0);
        @(negedge clk);
        chk("rel1.valid", 64'(fs_to_ds_valid), 64'h1);
        chk("rel1.bus",   fs_to_ds_bus,        {32'h1c000000, 32'h0000c0de});
        @(negedge clk);
        chk("rel2.valid", 64'(fs_to_ds_valid), 64'h1);
        chk("rel2.bus",   fs_to_ds_bus,        {32'h1c000004, 32'h0004c0de});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
